// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter with return-address stack:
// command encoding, strobe-priority decode and a constant-width log2 helper.
package pc_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_BRANCH,
        CMD_LOAD,
        CMD_CALL,
        CMD_RET,
        CMD_ILLEGAL
    } pc_cmd_e;

    // Ceiling log2, used to size the stack pointer (clog2(DEPTH+1) bits hold 0..DEPTH).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Highest-priority strobe wins; call together with ret is the one illegal combination.
    function automatic pc_cmd_e decode_cmd(input logic call, input logic ret, input logic load,
                                           input logic branch, input logic inc);
        pc_cmd_e cmd;
        if (call && ret)  cmd = CMD_ILLEGAL;
        else if (ret)     cmd = CMD_RET;
        else if (call)    cmd = CMD_CALL;
        else if (load)    cmd = CMD_LOAD;
        else if (branch)  cmd = CMD_BRANCH;
        else if (inc)     cmd = CMD_INC;
        else              cmd = CMD_HOLD;
        return cmd;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: push/pop one entry per cycle, occupancy count and full/empty flags.
// The caller guarantees no push when full and no pop when empty.
module ret_stack
    import pc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 push_data,
    output logic [W-1:0]                 top_data,
    output logic [clog2(DEPTH+1)-1:0]    sp,
    output logic                         full,
    output logic                         empty
);
    localparam int SP_W = clog2(DEPTH + 1);

    // Sized to the full sp range so sp indexes it directly; entries at or above DEPTH are never written.
    logic [W-1:0]    mem_q [2**SP_W];
    logic [W-1:0]    mem_d [2**SP_W];
    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] sp_d;
    logic [SP_W-1:0] top_idx;

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        if (push) begin
            mem_d[sp_q] = push_data;
            sp_d        = sp_q + SP_W'(1);
        end else if (pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) sp_q <= '0;
        else       sp_q <= sp_d;
    end

    // Contents need no reset: an empty stack is never read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top_idx  = sp_q - SP_W'(1);
    assign top_data = mem_q[top_idx];
    assign sp       = sp_q;
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);

endmodule

// File: rtl/program_counter_stack.sv
// Parametrised program counter: load, increment, PC-relative branch and call/return
// through a hardware LIFO, with a sticky error flag for stack misuse.
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int               PC_W        = 8,
    parameter int               STACK_DEPTH = 4,
    parameter logic [PC_W-1:0]  RESET_VEC   = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pc_load,
    input  logic                              pc_inc,
    input  logic                              pc_branch,
    input  logic                              call,
    input  logic                              ret,
    input  logic [PC_W-1:0]                   load_in,
    input  logic [PC_W-1:0]                   branch_off,
    output logic [PC_W-1:0]                   pc,
    output logic [clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                              stack_full,
    output logic                              stack_empty,
    output logic                              stack_err
);
    localparam int SP_W = clog2(STACK_DEPTH + 1);

    pc_cmd_e         cmd;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic            push, pop;
    logic [PC_W-1:0] top_data;
    logic [SP_W-1:0] sp_w;
    logic            full_w, empty_w;

    assign cmd = decode_cmd(call, ret, pc_load, pc_branch, pc_inc);

    // Branch offset is two's complement; modular addition at PC_W bits covers both directions.
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        push  = 1'b0;
        pop   = 1'b0;
        unique case (cmd)
            CMD_INC:     pc_d = pc_q + PC_W'(1);
            CMD_BRANCH:  pc_d = pc_q + branch_off;
            CMD_LOAD:    pc_d = load_in;
            CMD_CALL: begin
                if (full_w) begin
                    err_d = 1'b1;
                end else begin
                    push = 1'b1;
                    pc_d = load_in;
                end
            end
            CMD_RET: begin
                if (empty_w) begin
                    err_d = 1'b1;
                end else begin
                    pop  = 1'b1;
                    pc_d = top_data;
                end
            end
            CMD_ILLEGAL: err_d = 1'b1;
            default:     pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    // Reset also holds off push/pop inside the stack, so an interrupted call records nothing.
    ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + PC_W'(1)),
        .top_data  (top_data),
        .sp        (sp_w),
        .full      (full_w),
        .empty     (empty_w)
    );

    assign pc          = pc_q;
    assign sp          = sp_w;
    assign stack_full  = full_w;
    assign stack_empty = empty_w;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench for program_counter_stack: stimulus updates a queue-based reference
// model and pushes the expected state; a monitor pops and compares after every clock edge.
module tb_program_counter_stack;

    localparam int PC_W  = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pc_load = 1'b0, pc_inc = 1'b0, pc_branch = 1'b0, call = 1'b0, ret = 1'b0;
    logic [PC_W-1:0]  load_in = '0, branch_off = '0;
    logic [PC_W-1:0]  pc;
    logic [2:0]       sp;
    logic             stack_full, stack_empty, stack_err;

    program_counter_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (DEPTH),
        .RESET_VEC   (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .pc_branch   (pc_branch),
        .call        (call),
        .ret         (ret),
        .load_in     (load_in),
        .branch_off  (branch_off),
        .pc          (pc),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int sp;
        int full;
        int empty;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_pc = 0;
    int m_err = 0;
    int m_stk[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    function automatic void model_step(input bit r, input bit ld, input bit in, input bit br,
                                       input bit ca, input bit re, input int li, input int off);
        if (r) begin
            m_pc  = 0;
            m_err = 0;
            m_stk.delete();
        end else if (ca && re) begin
            m_err = 1;
        end else if (re) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else                  m_err = 1;
        end else if (ca) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back((m_pc + 1) % 256);
                m_pc = li;
            end else begin
                m_err = 1;
            end
        end else if (ld) begin
            m_pc = li;
        end else if (br) begin
            m_pc = (m_pc + off) % 256;
        end else if (in) begin
            m_pc = (m_pc + 1) % 256;
        end
    endfunction

    task automatic drive(input bit r, input bit ld, input bit in, input bit br,
                         input bit ca, input bit re, input int li, input int off);
        exp_t e;
        @(negedge clk);
        reset      = r;
        pc_load    = ld;
        pc_inc     = in;
        pc_branch  = br;
        call       = ca;
        ret        = re;
        load_in    = PC_W'(li);
        branch_off = PC_W'(off);
        model_step(r, ld, in, br, ca, re, li, off);
        e.pc    = m_pc;
        e.sp    = m_stk.size();
        e.full  = (m_stk.size() == DEPTH);
        e.empty = (m_stk.size() == 0);
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge that had stimulus behind it has an expected entry waiting.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", int'(pc), e.pc);
                check("sp", int'(sp), e.sp);
                check("stack_full", int'(stack_full), e.full);
                check("stack_empty", int'(stack_empty), e.empty);
                check("stack_err", int'(stack_err), e.err);
            end
        end
    end

    initial begin
        int wait_cycles;
        // 1: reset then free-running increment through the wrap
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) drive(0, 0, 1, 0, 0, 0, 0, 0);

        // 2: load beats inc, then branch backwards and forwards
        drive(0, 1, 0, 0, 0, 0, 8'h10, 0);
        drive(0, 1, 1, 0, 0, 0, 8'h40, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 8'hFE);
        drive(0, 0, 0, 1, 0, 0, 0, 8'h05);

        // 3: nested call and return
        drive(0, 1, 0, 0, 0, 0, 8'h20, 0);
        drive(0, 0, 0, 0, 1, 0, 8'h80, 0);
        drive(0, 0, 0, 0, 1, 0, 8'h90, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);

        // 4: fill the stack, overflow, then return the last push
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 0, 0, 1, 0, 8'h30 + i, 0);
        drive(0, 0, 1, 0, 1, 0, 8'hAA, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);

        // 5: underflow, illegal call&ret, reset clears the sticky flag
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 8'h77, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // 6: reset overrides a call with one entry already stacked
        drive(0, 0, 0, 0, 1, 0, 8'h55, 0);
        drive(1, 0, 0, 0, 1, 0, 8'h66, 0);
        idle();
        drive(0, 0, 0, 0, 0, 1, 0, 0);

        // Random traffic, call/ret-heavy so full/empty boundaries are visited often
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 60) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 255),
                  $urandom_range(0, 255));
        end
        idle();

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
